// File: rtl/uart_tx_serializer_if.sv
// Host-side bus of the UART transmit serializer: word/config handshake plus line and status.
interface uart_tx_serializer_if #(
  parameter int MAX_DATA = 9,
  parameter int LEN_W    = 4,
  parameter int DIV_W    = 16
);
  logic [MAX_DATA-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [LEN_W-1:0]    data_len;
  logic [1:0]          parity_type;
  logic                stop_bits;
  logic [DIV_W-1:0]    baud_div;
  logic                tx;
  logic                busy;
  logic                done;

  modport master (
    output in_data, in_valid, data_len, parity_type, stop_bits, baud_div,
    input  in_ready, tx, busy, done
  );

  modport slave (
    input  in_data, in_valid, data_len, parity_type, stop_bits, baud_div,
    output in_ready, tx, busy, done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: latches word and frame config on accept, then drives
// start, LSB-first data, optional parity and 1/2 stop bits at baud_div+1 clocks per bit.
module uart_tx_serializer #(
  parameter int MAX_DATA = 9,
  parameter int LEN_W    = 4,
  parameter int DIV_W    = 16
) (
  input logic             clk,
  input logic             rst,
  uart_tx_serializer_if.slave s
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < LEN_W'(5))             return LEN_W'(5);
    else if (l > LEN_W'(MAX_DATA)) return LEN_W'(MAX_DATA);
    else                           return l;
  endfunction

  // Parity covers only the bits that will actually be sent.
  function automatic logic calc_parity(input logic [MAX_DATA-1:0] d,
                                       input logic [LEN_W-1:0]    l,
                                       input logic                odd);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DATA; i++)
      if (i < int'(l)) p = p ^ d[i];
    return p ^ odd;
  endfunction

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [LEN_W-1:0]    bit_q, bit_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                stop_q, stop_d;
  logic                two_stop_q, two_stop_d;
  logic                par_en_q, par_en_d;
  logic [MAX_DATA-1:0] data_q, data_d;
  logic                par_bit_q, par_bit_d;
  logic                tx_q, tx_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                period_end;
  logic [LEN_W-1:0]    acc_len;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    len_d      = len_q;
    stop_d     = stop_q;
    two_stop_d = two_stop_q;
    par_en_d   = par_en_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    period_end = (cnt_q == div_q);
    acc_len    = clamp_len(s.data_len);

    case (state_q)
      IDLE: begin
        if (s.in_valid && rdy_q) begin
          state_d    = START;
          cnt_d      = '0;
          bit_d      = '0;
          stop_d     = 1'b0;
          div_d      = s.baud_div;
          len_d      = acc_len;
          two_stop_d = s.stop_bits;
          par_en_d   = (s.parity_type == 2'b01) || (s.parity_type == 2'b10);
          data_d     = s.in_data;
          par_bit_d  = calc_parity(s.in_data, acc_len, s.parity_type == 2'b01);
        end
      end
      START: begin
        if (period_end) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (period_end) begin
          cnt_d = '0;
          if (bit_q == len_q - LEN_W'(1)) begin
            state_d = par_en_q ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + LEN_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      PARITY: begin
        if (period_end) begin
          state_d = STOP;
          cnt_d   = '0;
          stop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (period_end) begin
          cnt_d = '0;
          if (stop_q == two_stop_q) state_d = IDLE;
          else                      stop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with the state they describe.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (stop_d == two_stop_d) && (cnt_d == div_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      len_q      <= LEN_W'(5);
      stop_q     <= 1'b0;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      tx_q       <= 1'b1;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      len_q      <= len_d;
      stop_q     <= stop_d;
      two_stop_q <= two_stop_d;
      par_en_q   <= par_en_d;
      tx_q       <= tx_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q    <= data_d;
    par_bit_q <= par_bit_d;
  end

  assign s.tx       = tx_q;
  assign s.in_ready = rdy_q;
  assign s.busy     = busy_q;
  assign s.done     = done_q;

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parametrised UART transmit engine: the next generation of the TX framing path. Accepts a data word over a valid/ready handshake and computes parity internally. Builds the frame for a runtime-selected data length, parity mode and stop-bit count, then serialises it LSB-first on `tx` using an internal baud divider. It sits between the TX FIFO/host interface and the pad, replacing the combinational framer plus external parity and shift logic.

## Interface
- `MAX_DATA`, default 9: maximum data bits per frame, legal 5..9.
- `LEN_W`, default 4: width of `data_len`.
- `DIV_W`, default 16: width of the baud divisor.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_data` input MAX_DATA: word to send; bit 0 is transmitted first.
- `in_valid` input 1: `in_data` and config are valid.
- `in_ready` output 1: block can accept a word.
- `data_len` input LEN_W: data bits per frame (5..MAX_DATA).
- `parity_type` input 2: 00 none, 01 odd, 10 even, 11 none.
- `stop_bits` input 1: 0 means one stop bit, 1 means two.
- `baud_div` input DIV_W: bit period is `baud_div+1` clocks.
- `tx` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1, `in_ready`=1, `busy`=0.
- Accept: `in_valid && in_ready` in IDLE.
  - On accept, latch `in_data`, `data_len`, `parity_type`, `stop_bits` and `baud_div` together.
  - Input changes after accept have no effect on the current frame.
- Length clamp at accept:
  - `data_len` < 5 is treated as 5.
  - `data_len` > MAX_DATA is treated as MAX_DATA.
- Parity is computed at accept over the latched bits [len-1:0] only.
  - Even parity: XOR of those bits.
  - Odd parity: inverse of that XOR.
- START: `tx`=0 for one bit period.
- DATA: bits 0..len-1 on `tx`, one bit period each. A bit counter advances at each period end.
- PARITY: entered only when `parity_type` is 01 or 10; otherwise DATA goes directly to STOP. `tx` = parity bit for one period.
- STOP: `tx`=1 for 1 or 2 bit periods. At the end of the last period: `done`=1 for one clock, state returns to IDLE.
- Baud counter:
  - Reloads to 0 on accept and at each bit boundary.
  - A bit period ends when the count equals the latched `baud_div`.
  - `baud_div`=0 gives one clock per bit.
- `busy` = (state != IDLE). `in_ready` = (state == IDLE).
- Reset (any time, including mid-frame):
  - `tx`=1, `in_ready`=1, `busy`=0, `done`=0, state IDLE.
  - Counters cleared; the partial frame is discarded.
  - Reset is asserted asynchronously; deassertion takes effect on the next rising clock edge.

## Timing
- Accept on edge N: `tx` goes 0 after edge N and stays low for `baud_div+1` clocks.
- Frame length in clocks = (1 + len + P + S) × (`baud_div`+1), where:
  - P = 1 when parity is enabled, else 0.
  - S = `stop_bits`+1.
- `done` is high during the final clock of the last stop bit. IDLE (`in_ready`=1) follows on the next edge.
- Back-to-back frames:
  - Minimum one IDLE clock with `tx`=1 between the last stop bit and the next start bit.
  - A word offered while busy is held by the source (`in_valid` stays high) and is accepted in that IDLE clock.
- `in_valid` high with `in_ready` low: no state change, no data loss.
- `tx`, `in_ready`, `busy` and `done` are registered outputs with no combinational path from inputs.

## Test plan
- 8-bit, even parity, 1 stop, `baud_div`=3, `in_data`=0x55 -> `tx` = 0,1,0,1,0,1,0,1,0,0(parity),1. Each value lasts 4 clocks, 44 clocks total, `done` pulses once.
- 7-bit, odd parity, 2 stop, `baud_div`=0, `in_data`=0x41 -> `tx` = 0,1,0,0,0,0,0,1,1(parity),1,1. 11 clocks total.
- 9-bit (MAX_DATA=9), no parity (11), 1 stop, `in_data`=0x1FF -> start bit, nine 1s, stop bit. 11 bit periods; `data_len`=12 gives the same 9-bit frame (clamp).
- Back-to-back: `in_valid` held high with words 0xA5 then 0x3C, 5-bit no parity -> second word accepted exactly one IDLE clock after the first `done`; bits 0x05 then 0x1C appear LSB-first.
- Mid-frame changes: change `data_len`, `parity_type` and `baud_div` during DATA -> the current frame is unchanged.
- Reset during the PARITY state -> `tx`=1 and `in_ready`=1 immediately, `done` never pulses. The next frame after reset release is correct.
